// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and line-state encodings for the USB Tx NRZI path
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        EOP_SE0 = 2'd2,
        EOP_J   = 2'd3
    } tx_enc_state_t;

    // Line states are {d_plus, d_minus}; J/K polarity depends on bus speed.
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [1:0] line_j(input logic full_speed);
        return full_speed ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] line_k(input logic full_speed);
        return full_speed ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/usb_bit_counter.sv
// rtl/usb_bit_counter.sv - 4-bit bit-time counter with load-to-1 and terminal compare
module usb_bit_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_en,
    input  logic [3:0] i_term,
    output logic       o_terminal
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= 4'd1;
        end else if (i_en) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_terminal = (r_count == i_term);

endmodule

// File: rtl/usb_tx_nrzi_encoder.sv
// rtl/usb_tx_nrzi_encoder.sv - NRZI line encoder with idle J hold and EOP generation
module usb_tx_nrzi_encoder
    import usb_tx_pkg::*;
#(
    parameter bit FULL_SPEED   = 1'b1,
    parameter int EOP_SE0_BITS = 2,
    parameter int EOP_J_BITS   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_enable,
    input  logic tx_start,
    input  logic d_orig,
    input  logic stop_clock_shift_enable,
    input  logic eop_request,
    output logic d_plus,
    output logic d_minus,
    output logic tx_busy,
    output logic eop_done
);

    localparam logic [1:0] LINE_J   = line_j(FULL_SPEED);
    localparam logic [1:0] LINE_K   = line_k(FULL_SPEED);
    localparam logic [3:0] SE0_TERM = 4'(EOP_SE0_BITS);
    localparam logic [3:0] J_TERM   = 4'(EOP_J_BITS);

    tx_enc_state_t r_state;
    logic [1:0]    r_line;
    logic          r_busy;
    logic          r_done;
    logic          r_eop_pending;

    logic          w_bit;
    logic          w_terminal;
    logic          w_cnt_load;
    logic          w_cnt_en;
    logic [3:0]    w_term;

    // A stuff bit is always a zero, i.e. a forced transition.
    assign w_bit  = d_orig & ~stop_clock_shift_enable;
    assign w_term = (r_state == EOP_J) ? J_TERM : SE0_TERM;

    assign w_cnt_load = shift_enable &
                        (((r_state == DATA) && r_eop_pending) ||
                         ((r_state == EOP_SE0) && w_terminal));
    assign w_cnt_en   = shift_enable & ~w_terminal &
                        ((r_state == EOP_SE0) || (r_state == EOP_J));

    usb_bit_counter u_bit_counter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_cnt_load),
        .i_en       (w_cnt_en),
        .i_term     (w_term),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_line        <= LINE_J;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_eop_pending <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_line        <= LINE_J;
                    r_eop_pending <= 1'b0;
                    // A start coinciding with the completion pulse is dropped.
                    if (tx_start && !r_done) begin
                        r_state <= DATA;
                        r_busy  <= 1'b1;
                    end
                end
                DATA: begin
                    if (shift_enable && r_eop_pending) begin
                        r_line        <= LINE_SE0;
                        r_state       <= EOP_SE0;
                        r_eop_pending <= 1'b0;
                    end else begin
                        if (eop_request) begin
                            r_eop_pending <= 1'b1;
                        end
                        if (shift_enable && !w_bit) begin
                            r_line <= (r_line == LINE_J) ? LINE_K : LINE_J;
                        end
                    end
                end
                EOP_SE0: begin
                    if (shift_enable && w_terminal) begin
                        r_line  <= LINE_J;
                        r_state <= EOP_J;
                    end
                end
                EOP_J: begin
                    if (shift_enable && w_terminal) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_line  <= LINE_J;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_line != 2'b11);
        end
    end

    assign d_plus   = r_line[1];
    assign d_minus  = r_line[0];
    assign tx_busy  = r_busy;
    assign eop_done = r_done;

endmodule

// File: tb/tb_usb_tx_nrzi_encoder.sv
// tb/tb_usb_tx_nrzi_encoder.sv - directed vector bench for the USB Tx NRZI encoder
module tb_usb_tx_nrzi_encoder;

    localparam logic [1:0] J = 2'b10;
    localparam logic [1:0] K = 2'b01;
    localparam logic [1:0] S = 2'b00;

    typedef struct {
        logic       rst;
        logic       se;
        logic       start;
        logic       d;
        logic       stop;
        logic       eopr;
        logic [1:0] line;
        logic       busy;
        logic       done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic shift_enable = 1'b0;
    logic tx_start = 1'b0;
    logic d_orig = 1'b0;
    logic stop_clock_shift_enable = 1'b0;
    logic eop_request = 1'b0;
    logic d_plus;
    logic d_minus;
    logic tx_busy;
    logic eop_done;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    usb_tx_nrzi_encoder dut (
        .clk                     (clk),
        .rst                     (rst),
        .shift_enable            (shift_enable),
        .tx_start                (tx_start),
        .d_orig                  (d_orig),
        .stop_clock_shift_enable (stop_clock_shift_enable),
        .eop_request             (eop_request),
        .d_plus                  (d_plus),
        .d_minus                 (d_minus),
        .tx_busy                 (tx_busy),
        .eop_done                (eop_done)
    );

    function automatic vec_t mk(input logic r, input logic se, input logic st,
                                input logic d, input logic sp, input logic er,
                                input logic [1:0] ln, input logic b, input logic dn);
        vec_t v;
        v.rst = r; v.se = se; v.start = st; v.d = d; v.stop = sp; v.eopr = er;
        v.line = ln; v.busy = b; v.done = dn;
        return v;
    endfunction

    task automatic step(input vec_t v, input string name, input int idx);
        logic [3:0] got;
        logic [3:0] want;
        rst = v.rst;
        shift_enable = v.se;
        tx_start = v.start;
        d_orig = v.d;
        stop_clock_shift_enable = v.stop;
        eop_request = v.eopr;
        @(posedge clk);
        #1;
        got  = {d_plus, d_minus, tx_busy, eop_done};
        want = {v.line, v.busy, v.done};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] {dp,dm,busy,done} got %b expected %b", name, idx, got, want);
        end
    endtask

    initial begin
        // reset, then idle strobes that must be ignored
        tbl.push_back(mk(1,0,0,0,0,0,J,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,J,0,0));
        for (int i = 0; i < 10; i++) begin
            tbl.push_back(mk(0,1,0,1'(i % 2),0,1'(i == 3),J,0,0));
        end
        // SYNC pattern, with one gap cycle to check that the line only moves on strobes
        tbl.push_back(mk(0,0,1,0,0,0,J,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,K,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,K,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,J,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,K,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,J,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,K,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,J,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,K,1,0));
        tbl.push_back(mk(0,1,0,1,0,0,K,1,0));
        // stuff bit overrides d_orig=1
        tbl.push_back(mk(0,1,0,0,0,0,J,1,0));
        tbl.push_back(mk(0,1,0,1,1,0,K,1,0));
        tbl.push_back(mk(0,1,0,1,0,0,K,1,0));
        // EOP: 2 SE0 bit times, 1 J bit time, then done
        tbl.push_back(mk(0,0,0,0,0,1,K,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,S,1,0));
        tbl.push_back(mk(0,1,0,1,0,0,S,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,S,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,J,1,0));
        tbl.push_back(mk(0,1,0,0,0,0,J,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,J,0,0));
        tbl.push_back(mk(0,1,0,0,0,0,J,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], "table", i);
        end

        // eop_request with a data strobe, then tx_start on the eop_done cycle
        step(mk(0,0,1,0,0,0,J,1,0), "simul", 0);
        step(mk(0,1,0,0,0,0,K,1,0), "simul", 1);
        step(mk(0,1,0,0,0,1,J,1,0), "simul", 2);
        step(mk(0,1,0,0,0,0,S,1,0), "simul", 3);
        step(mk(0,1,0,0,0,0,S,1,0), "simul", 4);
        step(mk(0,1,0,0,0,0,J,1,0), "simul", 5);
        step(mk(0,1,0,0,0,0,J,0,1), "simul", 6);
        step(mk(0,0,1,0,0,0,J,0,0), "simul", 7);
        step(mk(0,1,0,0,0,0,J,0,0), "simul", 8);

        // reset during EOP_SE0 aborts without eop_done; restart works
        step(mk(0,0,1,0,0,0,J,1,0), "rst_eop", 0);
        step(mk(0,1,0,0,0,0,K,1,0), "rst_eop", 1);
        step(mk(0,0,0,0,0,1,K,1,0), "rst_eop", 2);
        step(mk(0,1,0,0,0,0,S,1,0), "rst_eop", 3);
        step(mk(1,0,0,0,0,0,J,0,0), "rst_eop", 4);
        step(mk(0,1,0,0,0,0,J,0,0), "rst_eop", 5);
        step(mk(0,1,0,0,0,0,J,0,0), "rst_eop", 6);
        step(mk(0,1,0,0,0,0,J,0,0), "rst_eop", 7);
        step(mk(0,0,1,0,0,0,J,1,0), "rst_eop", 8);
        step(mk(0,1,0,0,0,0,K,1,0), "rst_eop", 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
